// File: rtl/bcd_count_ctrl.sv
// Shared multi-digit BCD up/down counter: arbitrates inc/dec requesters and ripples
// each command through the digits LSD first, one digit per clock.
//   state  | meaning
//   IDLE   | waiting for load or a request; round-robin on contention
//   RIPPLE | updating digit k in direction dir_inc; completes on first non-wrapping digit
module bcd_count_ctrl #(
  parameter int DIGITS   = 4,
  parameter int SATURATE = 0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  inc_req,
  input  logic                  dec_req,
  output logic                  inc_ack,
  output logic                  dec_ack,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_value,
  input  logic                  hold,
  output logic [4*DIGITS-1:0]   count,
  output logic                  busy,
  output logic                  carry_out,
  output logic                  borrow_out,
  output logic                  at_max,
  output logic                  at_zero
);

  localparam int KW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(DIGITS - 1);

  typedef enum logic {IDLE, RIPPLE} state_t;

  state_t          state;
  logic [KW-1:0]   k;
  logic            dir_inc;
  logic            pref_inc;

  logic [3:0]            digit_k;
  logic [3:0]            digit_next;
  logic                  wraps;
  logic                  sat_hold;
  logic                  grant_inc;
  logic [4*DIGITS-1:0]   load_clamped;

  always_comb begin
    digit_k      = '0;
    at_max       = 1'b1;
    at_zero      = 1'b1;
    load_clamped = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (k == KW'(i)) digit_k = count[4*i +: 4];
      if (count[4*i +: 4] != 4'd9) at_max = 1'b0;
      if (count[4*i +: 4] != 4'd0) at_zero = 1'b0;
      load_clamped[4*i +: 4] = (load_value[4*i +: 4] > 4'd9) ? 4'd9 : load_value[4*i +: 4];
    end
  end

  always_comb begin
    wraps      = dir_inc ? (digit_k == 4'd9) : (digit_k == 4'd0);
    digit_next = '0;
    if (dir_inc) digit_next = wraps ? 4'd0 : digit_k + 4'd1;
    else         digit_next = wraps ? 4'd9 : digit_k - 4'd1;
    // k is zero only on the first ripple edge, which is where saturation is decided
    sat_hold  = (SATURATE != 0) && (k == '0) && (dir_inc ? at_max : at_zero);
    grant_inc = inc_req && (!dec_req || pref_inc);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      k          <= '0;
      dir_inc    <= 1'b1;
      pref_inc   <= 1'b1;
      count      <= '0;
      busy       <= 1'b0;
      inc_ack    <= 1'b0;
      dec_ack    <= 1'b0;
      carry_out  <= 1'b0;
      borrow_out <= 1'b0;
    end else begin
      inc_ack    <= 1'b0;
      dec_ack    <= 1'b0;
      carry_out  <= 1'b0;
      borrow_out <= 1'b0;
      if (!hold) begin
        unique case (state)
          IDLE: begin
            if (load) begin
              count <= load_clamped;
            end else if (inc_req || dec_req) begin
              dir_inc <= grant_inc;
              k       <= '0;
              state   <= RIPPLE;
              busy    <= 1'b1;
              if (inc_req && dec_req) pref_inc <= !grant_inc;
            end
          end
          RIPPLE: begin
            if (sat_hold) begin
              state      <= IDLE;
              busy       <= 1'b0;
              k          <= '0;
              inc_ack    <= dir_inc;
              dec_ack    <= !dir_inc;
              carry_out  <= dir_inc;
              borrow_out <= !dir_inc;
            end else begin
              for (int i = 0; i < DIGITS; i++)
                if (k == KW'(i)) count[4*i +: 4] <= digit_next;
              if (wraps && (k != K_LAST)) begin
                k <= k + 1'b1;
              end else begin
                state      <= IDLE;
                busy       <= 1'b0;
                k          <= '0;
                inc_ack    <= dir_inc;
                dec_ack    <= !dir_inc;
                carry_out  <= wraps && dir_inc;
                borrow_out <= wraps && !dir_inc;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bcd_count_ctrl.sv
// Bench for bcd_count_ctrl: a wrapping and a saturating instance, both checked every
// cycle against an integer-valued model, plus directed cases with literal expectations.
module tb_bcd_count_ctrl;

  localparam int MAXV = 9999;
  localparam int P4   = 10000;

  typedef struct packed {
    int cnt;
    int v;
    int m;
    int j;
    bit busy;
    bit dir_inc;
    bit sat;
    bit pref_inc;
    bit inc_ack;
    bit dec_ack;
    bit carry;
    bit borrow;
  } model_t;

  logic        clock;
  logic        reset;
  logic        inc_req    [2];
  logic        dec_req    [2];
  logic        load       [2];
  logic        hold       [2];
  logic [15:0] load_value [2];
  logic        d_inc_ack  [2];
  logic        d_dec_ack  [2];
  logic [15:0] d_count    [2];
  logic        d_busy     [2];
  logic        d_carry    [2];
  logic        d_borrow   [2];
  logic        d_at_max   [2];
  logic        d_at_zero  [2];

  model_t ms [2];
  int checks = 0;
  int errors = 0;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    bcd_count_ctrl #(.DIGITS(4), .SATURATE(g)) dut (
      .clock(clock), .reset(reset),
      .inc_req(inc_req[g]), .dec_req(dec_req[g]),
      .inc_ack(d_inc_ack[g]), .dec_ack(d_dec_ack[g]),
      .load(load[g]), .load_value(load_value[g]), .hold(hold[g]),
      .count(d_count[g]), .busy(d_busy[g]),
      .carry_out(d_carry[g]), .borrow_out(d_borrow[g]),
      .at_max(d_at_max[g]), .at_zero(d_at_zero[g])
    );
  end

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic int p10(input int d);
    int r = 1;
    repeat (d) r = r * 10;
    return r;
  endfunction

  function automatic int dig(input int v, input int d);
    return (v / p10(d)) % 10;
  endfunction

  function automatic logic [15:0] int2bcd(input int v);
    logic [15:0] r = '0;
    for (int d = 0; d < 4; d++) r[4*d +: 4] = 4'(dig(v, d));
    return r;
  endfunction

  function automatic int clamp_load(input logic [15:0] b);
    int r = 0;
    for (int d = 3; d >= 0; d--) begin
      int nib = int'(b[4*d +: 4]);
      r = r * 10 + ((nib > 9) ? 9 : nib);
    end
    return r;
  endfunction

  function automatic model_t model_reset();
    model_t n = '0;
    n.pref_inc = 1'b1;
    n.dir_inc  = 1'b1;
    return n;
  endfunction

  // One clock of the reference: the count is a plain integer 0..9999
  function automatic model_t step(input model_t s, input bit sat_mode, input bit ir, input bit dr,
                                  input bit ld, input logic [15:0] lv, input bit hd);
    model_t n = s;
    int t;
    n.inc_ack = 0; n.dec_ack = 0; n.carry = 0; n.borrow = 0;
    if (hd) return n;
    if (!s.busy) begin
      if (ld) begin
        n.cnt = clamp_load(lv);
      end else if (ir || dr) begin
        n.dir_inc = ir && (!dr || s.pref_inc);
        if (ir && dr) n.pref_inc = !n.dir_inc;
        n.busy = 1; n.v = s.cnt; n.j = 0;
        n.sat = sat_mode && (n.dir_inc ? (s.cnt == MAXV) : (s.cnt == 0));
        if (n.sat) n.m = 1;
        else begin
          t = 0;
          while (t < 4 && dig(s.cnt, t) == (n.dir_inc ? 9 : 0)) t++;
          n.m = (t < 4) ? t + 1 : 4;
        end
      end
    end else begin
      n.j = s.j + 1;
      if (n.j == s.m) begin
        n.busy = 0;
        if (!s.sat) n.cnt = s.dir_inc ? (s.v + 1) % P4 : (s.v + P4 - 1) % P4;
        if (s.dir_inc) begin n.inc_ack = 1; n.carry  = (s.v == MAXV); end
        else           begin n.dec_ack = 1; n.borrow = (s.v == 0);    end
      end else begin
        n.cnt = s.dir_inc ? s.v - (p10(n.j) - 1) : s.v + (p10(n.j) - 1);
      end
    end
    return n;
  endfunction

  always @(posedge clock or negedge reset) begin
    for (int i = 0; i < 2; i++) begin
      if (!reset) ms[i] <= model_reset();
      else ms[i] <= step(ms[i], (i == 1), inc_req[i], dec_req[i], load[i], load_value[i], hold[i]);
    end
  end

  task automatic chk(input string nm, input int i, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s dut%0d at %0t: actual=%0h expected=%0h", nm, i, $time, act, exp);
    end
  endtask

  always @(posedge clock) begin
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("count",   i, int'(d_count[i]),   int'(int2bcd(ms[i].cnt)));
      chk("busy",    i, int'(d_busy[i]),    int'(ms[i].busy));
      chk("inc_ack", i, int'(d_inc_ack[i]), int'(ms[i].inc_ack));
      chk("dec_ack", i, int'(d_dec_ack[i]), int'(ms[i].dec_ack));
      chk("carry",   i, int'(d_carry[i]),   int'(ms[i].carry));
      chk("borrow",  i, int'(d_borrow[i]),  int'(ms[i].borrow));
      chk("at_max",  i, int'(d_at_max[i]),  int'(ms[i].cnt == MAXV));
      chk("at_zero", i, int'(d_at_zero[i]), int'(ms[i].cnt == 0));
    end
  end

  task automatic load_both(input logic [15:0] v);
    @(negedge clock);
    load[0] = 1; load[1] = 1; load_value[0] = v; load_value[1] = v;
    @(negedge clock);
    load[0] = 0; load[1] = 0;
  endtask

  task automatic cmd(input int i, input bit is_inc, input int hold_at, input int hold_len,
                     output int edges, output bit flag, output logic [15:0] frozen);
    bit done = 0;
    edges = 0; flag = 0; frozen = '0;
    @(negedge clock);
    if (is_inc) inc_req[i] = 1; else dec_req[i] = 1;
    while (!done && edges < 40) begin
      @(posedge clock); #1;
      edges++;
      if (hold_len > 0 && edges == hold_at + hold_len) frozen = d_count[i];
      if ((is_inc ? d_inc_ack[i] : d_dec_ack[i]) == 1'b1) begin
        done = 1;
        flag = is_inc ? d_carry[i] : d_borrow[i];
      end
      @(negedge clock);
      hold[i] = !done && hold_len > 0 && edges >= hold_at && edges < hold_at + hold_len;
    end
    inc_req[i] = 0; dec_req[i] = 0; hold[i] = 0;
    if (!done) chk("ack_timeout", i, 0, 1);
  endtask

  function automatic logic [15:0] pick_val();
    case ($urandom_range(0, 5))
      0: return 16'($urandom);
      1: return 16'h9999;
      2: return 16'h0000;
      3: return 16'h0999;
      4: return 16'h9000;
      default: return int2bcd($urandom_range(0, 9999));
    endcase
  endfunction

  int          edges;
  bit          flag;
  logic [15:0] frozen;
  logic [3:0]  order;
  int          n_acks;
  int          cyc;

  initial begin
    reset = 0;
    for (int i = 0; i < 2; i++) begin
      inc_req[i] = 0; dec_req[i] = 0; load[i] = 0; hold[i] = 0; load_value[i] = '0;
    end
    repeat (3) @(negedge clock);
    reset = 1;
    @(posedge clock); #1;
    chk("reset_count", 0, int'(d_count[0]), 0);
    chk("reset_busy", 0, int'(d_busy[0]), 0);
    chk("reset_at_zero", 0, int'(d_at_zero[0]), 1);

    // reset while an increment is rippling through 0999
    load_both(16'h0999);
    @(negedge clock); inc_req[0] = 1;
    repeat (2) @(posedge clock);
    #1 chk("busy_mid_ripple", 0, int'(d_busy[0]), 1);
    @(negedge clock); reset = 0;
    #1;
    chk("rst_mid_count", 0, int'(d_count[0]), 16'h0000);
    chk("rst_mid_busy", 0, int'(d_busy[0]), 0);
    chk("rst_mid_at_zero", 0, int'(d_at_zero[0]), 1);
    inc_req[0] = 0;
    @(posedge clock); #1;
    chk("rst_mid_no_ack", 0, int'(d_inc_ack[0]), 0);
    @(negedge clock); reset = 1;

    load_both(16'h0129);
    cmd(0, 1, 0, 0, edges, flag, frozen);
    chk("inc0129_edges", 0, edges, 3);
    chk("inc0129_count", 0, int'(d_count[0]), 16'h0130);
    chk("inc0129_carry", 0, int'(flag), 0);
    chk("inc0129_model", 0, ms[0].cnt, 130);

    load_both(16'h9999);
    cmd(0, 1, 0, 0, edges, flag, frozen);
    chk("inc9999_edges", 0, edges, 5);
    chk("inc9999_count", 0, int'(d_count[0]), 16'h0000);
    chk("inc9999_carry", 0, int'(flag), 1);
    chk("inc9999_at_zero", 0, int'(d_at_zero[0]), 1);
    cmd(1, 1, 0, 0, edges, flag, frozen);
    chk("sat_inc_edges", 1, edges, 2);
    chk("sat_inc_count", 1, int'(d_count[1]), 16'h9999);
    chk("sat_inc_carry", 1, int'(flag), 1);

    load_both(16'h1000);
    cmd(0, 0, 0, 0, edges, flag, frozen);
    chk("dec1000_edges", 0, edges, 5);
    chk("dec1000_count", 0, int'(d_count[0]), 16'h0999);
    chk("dec1000_model", 0, ms[0].cnt, 999);
    load_both(16'h0000);
    cmd(0, 0, 0, 0, edges, flag, frozen);
    chk("dec0000_count", 0, int'(d_count[0]), 16'h9999);
    chk("dec0000_borrow", 0, int'(flag), 1);
    cmd(1, 0, 0, 0, edges, flag, frozen);
    chk("sat_dec_edges", 1, edges, 2);
    chk("sat_dec_count", 1, int'(d_count[1]), 16'h0000);
    chk("sat_dec_borrow", 1, int'(flag), 1);

    // both requesters held; each drops only for the cycle after its own ack
    load_both(16'h0500);
    order = '0; n_acks = 0; cyc = 0;
    @(negedge clock); inc_req[0] = 1; dec_req[0] = 1;
    while (n_acks < 4 && cyc < 60) begin
      @(posedge clock); #1;
      cyc++;
      if (d_inc_ack[0]) begin order[3-n_acks] = 1'b1; n_acks++; end
      else if (d_dec_ack[0]) begin order[3-n_acks] = 1'b0; n_acks++; end
      @(negedge clock);
      inc_req[0] = !d_inc_ack[0] && n_acks < 4;
      dec_req[0] = !d_dec_ack[0] && n_acks < 4;
    end
    inc_req[0] = 0; dec_req[0] = 0;
    chk("rr_acks", 0, n_acks, 4);
    chk("rr_order", 0, int'(order), 4'b1010);
    chk("rr_count", 0, int'(d_count[0]), 16'h0500);

    load_both(16'h0099);
    cmd(0, 1, 2, 3, edges, flag, frozen);
    chk("hold_edges", 0, edges, 7);
    chk("hold_frozen", 0, int'(frozen), 16'h0090);
    chk("hold_count", 0, int'(d_count[0]), 16'h0100);

    load_both(16'hF3A7);
    @(posedge clock); #1;
    chk("clamp_count", 0, int'(d_count[0]), 16'h9397);
    chk("clamp_count", 1, int'(d_count[1]), 16'h9397);
    chk("clamp_model", 0, ms[0].cnt, 9397);

    repeat (4000) begin
      @(negedge clock);
      reset = ($urandom_range(0, 499) != 0);
      for (int i = 0; i < 2; i++) begin
        hold[i]       = ($urandom_range(0, 9) == 0);
        load[i]       = ($urandom_range(0, 19) == 0);
        load_value[i] = pick_val();
        if (d_inc_ack[i]) inc_req[i] = 0;
        else if (!inc_req[i] && $urandom_range(0, 3) == 0) inc_req[i] = 1;
        if (d_dec_ack[i]) dec_req[i] = 0;
        else if (!dec_req[i] && $urandom_range(0, 3) == 0) dec_req[i] = 1;
      end
    end
    @(negedge clock);
    reset = 1;
    for (int i = 0; i < 2; i++) begin
      inc_req[i] = 0; dec_req[i] = 0; load[i] = 0; hold[i] = 0;
    end
    repeat (12) @(posedge clock);
    #2;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
